// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencer: sequencer state encoding and the
// instruction word the datapath loads into a pipe register when told to bubble.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MEM_WAIT = 2'd1,
      HZ_ERR      = 2'd2
   } hz_state_t;

   // Canonical no-op (addi x0,x0,0) injected by the datapath on bubble/flush.
   localparam logic [31:0] BUBBLE = 32'h0000_0013;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear beats increment; increment stops once the counter is full.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Counter register, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: merges memory stall, branch flush,
// load-use interlock and fetch starvation into per-stage enables/bubbles,
// runs a memory-stall watchdog and keeps saturating performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             intrlock_bubble,
   input  logic             ex_branch_flush,
   input  logic             ma_mem_req,
   input  logic             ma_mem_ack,
   input  logic             if_inst_vld,
   input  logic             perf_clr,
   output logic             pc_en,
   output logic             if_de_en,
   output logic             if_de_flush,
   output logic             de_ex_en,
   output logic             de_ex_bubble,
   output logic             ex_ma_en,
   output logic             ma_wb_en,
   output logic             ma_wb_bubble,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_flush
);

   // A zero timeout disables the watchdog; keep the timer at least one bit wide.
   localparam int              TMR_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);
   localparam bit               WD_EN     = (MEM_TIMEOUT != 0);

   hz_state_t        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             err_q, err_d;

   logic mstall;
   logic sel_flush;
   logic active;

   assign mstall = ma_mem_req & ~ma_mem_ack;
   assign active = ~rst & (state_q != HZ_ERR);

   // Stage controls, first matching hazard wins; everything idles in reset/ERR.
   always_comb begin
      pc_en        = 1'b0;
      if_de_en     = 1'b0;
      if_de_flush  = 1'b0;
      de_ex_en     = 1'b0;
      de_ex_bubble = 1'b0;
      ex_ma_en     = 1'b0;
      ma_wb_en     = 1'b0;
      ma_wb_bubble = 1'b0;
      sel_flush    = 1'b0;
      if (active) begin
         if (mstall) begin
            // Freeze everything up to MA; WB drains with a bubble.
            ma_wb_en     = 1'b1;
            ma_wb_bubble = 1'b1;
         end else if (ex_branch_flush) begin
            // Redirect: kill the two younger instructions, interlock is moot.
            pc_en        = 1'b1;
            if_de_en     = 1'b1;
            if_de_flush  = 1'b1;
            de_ex_en     = 1'b1;
            de_ex_bubble = 1'b1;
            ex_ma_en     = 1'b1;
            ma_wb_en     = 1'b1;
            sel_flush    = 1'b1;
         end else if (intrlock_bubble) begin
            // Hold IF/DE, insert a bubble into EX, let older work drain.
            de_ex_en     = 1'b1;
            de_ex_bubble = 1'b1;
            ex_ma_en     = 1'b1;
            ma_wb_en     = 1'b1;
         end else if (!if_inst_vld) begin
            // Fetch starved: hold PC, push a bubble into decode.
            if_de_en     = 1'b1;
            if_de_flush  = 1'b1;
            de_ex_en     = 1'b1;
            ex_ma_en     = 1'b1;
            ma_wb_en     = 1'b1;
         end else begin
            pc_en        = 1'b1;
            if_de_en     = 1'b1;
            de_ex_en     = 1'b1;
            ex_ma_en     = 1'b1;
            ma_wb_en     = 1'b1;
         end
      end
   end

   // Next state: the timer counts consecutive stall cycles including the first.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         HZ_RUN: begin
            if (mstall) begin
               tmr_d   = TMR_ONE;
               state_d = (WD_EN && (TMR_ONE == TMR_LIMIT)) ? HZ_ERR : HZ_MEM_WAIT;
            end
         end
         HZ_MEM_WAIT: begin
            if (mstall) begin
               tmr_d = tmr_q + TMR_ONE;
               if (WD_EN && (tmr_d == TMR_LIMIT)) begin
                  state_d = HZ_ERR;
               end
            end else begin
               tmr_d   = '0;
               state_d = HZ_RUN;
            end
         end
         default: begin
            state_d = HZ_ERR;
         end
      endcase
      err_d = err_q | (state_d == HZ_ERR);
   end

   // Sequencer state, watchdog timer and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HZ_RUN;
         tmr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         err_q   <= err_d;
      end
   end

   assign mem_timeout_err = err_q;

   pipe_sat_cnt #(.W(CNT_W)) u_cnt_cycles (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (active),
      .cnt (perf_cycles)
   );

   pipe_sat_cnt #(.W(CNT_W)) u_cnt_stall (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (active & ~pc_en),
      .cnt (perf_stall)
   );

   pipe_sat_cnt #(.W(CNT_W)) u_cnt_flush (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (sel_flush),
      .cnt (perf_flush)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short watchdog and 4-bit counters.
module tb_pipe_hazard_ctrl;

   localparam int CW = 4;

   // {pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_bubble, ex_ma_en, ma_wb_en, ma_wb_bubble}
   localparam logic [7:0] V_OFF = 8'b0000_0000;
   localparam logic [7:0] V_RUN = 8'b1101_0110;
   localparam logic [7:0] V_MST = 8'b0000_0011;
   localparam logic [7:0] V_FLS = 8'b1111_1110;
   localparam logic [7:0] V_ILK = 8'b0001_1110;
   localparam logic [7:0] V_NOV = 8'b0111_0110;

   logic clk = 1'b0;
   logic rst, intrlock, branch, req, ack, vld, clr;
   logic pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_bubble, ex_ma_en, ma_wb_en, ma_wb_bubble;
   logic err;
   logic [CW-1:0] p_cyc, p_stall, p_flush;
   logic [7:0] vec;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign vec = {pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_bubble, ex_ma_en, ma_wb_en, ma_wb_bubble};

   pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .intrlock_bubble (intrlock),
      .ex_branch_flush (branch),
      .ma_mem_req      (req),
      .ma_mem_ack      (ack),
      .if_inst_vld     (vld),
      .perf_clr        (clr),
      .pc_en           (pc_en),
      .if_de_en        (if_de_en),
      .if_de_flush     (if_de_flush),
      .de_ex_en        (de_ex_en),
      .de_ex_bubble    (de_ex_bubble),
      .ex_ma_en        (ex_ma_en),
      .ma_wb_en        (ma_wb_en),
      .ma_wb_bubble    (ma_wb_bubble),
      .mem_timeout_err (err),
      .perf_cycles     (p_cyc),
      .perf_stall      (p_stall),
      .perf_flush      (p_flush)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      rst = 1'b1; intrlock = 1'b0; branch = 1'b0; req = 1'b0; ack = 1'b0; vld = 1'b1; clr = 1'b0;
      nxt; nxt; settle;
      chk("rst_outs", {24'd0, vec}, {24'd0, V_OFF});
      chk("rst_cycles", {28'd0, p_cyc}, 32'd0);
      chk("rst_stall", {28'd0, p_stall}, 32'd0);
      chk("rst_flush", {28'd0, p_flush}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0; settle;
      chk("run_idle", {24'd0, vec}, {24'd0, V_RUN});

      // Reset while waiting on memory
      for (int i = 0; i < 3; i++) begin
         nxt; req = 1'b1; ack = 1'b0; settle;
         chk("wait_pre_rst", {24'd0, vec}, {24'd0, V_MST});
      end
      nxt; rst = 1'b1; settle;
      chk("midwait_rst_outs", {24'd0, vec}, {24'd0, V_OFF});
      chk("midwait_rst_cycles", {28'd0, p_cyc}, 32'd0);
      chk("midwait_rst_stall", {28'd0, p_stall}, 32'd0);
      chk("midwait_rst_err", {31'd0, err}, 32'd0);
      nxt; req = 1'b0; rst = 1'b0; settle;
      chk("post_rst_run", {24'd0, vec}, {24'd0, V_RUN});
      chk("post_rst_cycles", {28'd0, p_cyc}, 32'd0);

      // Load-use interlock
      nxt;
      chk("cycles_count", {28'd0, p_cyc}, 32'd1);
      chk("stall_before_ilk", {28'd0, p_stall}, 32'd0);
      intrlock = 1'b1; settle;
      chk("ilk_outs", {24'd0, vec}, {24'd0, V_ILK});
      nxt; intrlock = 1'b0;
      chk("ilk_stall_cnt", {28'd0, p_stall}, 32'd1);
      clr = 1'b1; settle;
      chk("ilk_release", {24'd0, vec}, {24'd0, V_RUN});
      nxt; clr = 1'b0;
      chk("clr_stall", {28'd0, p_stall}, 32'd0);
      chk("clr_cycles", {28'd0, p_cyc}, 32'd0);

      // Memory wait of three cycles then ack
      req = 1'b1; ack = 1'b0; settle;
      chk("mw_c0", {24'd0, vec}, {24'd0, V_MST});
      nxt; settle;
      chk("mw_c1", {24'd0, vec}, {24'd0, V_MST});
      nxt; settle;
      chk("mw_c2", {24'd0, vec}, {24'd0, V_MST});
      nxt; ack = 1'b1; settle;
      chk("mw_c3_release", {24'd0, vec}, {24'd0, V_RUN});
      nxt; req = 1'b0; ack = 1'b0;
      chk("mw_stall_cnt", {28'd0, p_stall}, 32'd3);
      chk("mw_no_err", {31'd0, err}, 32'd0);
      chk("mw_flush_cnt", {28'd0, p_flush}, 32'd0);

      // Flush and interlock in the same cycle
      intrlock = 1'b1; branch = 1'b1; settle;
      chk("fls_vs_ilk", {24'd0, vec}, {24'd0, V_FLS});
      nxt; intrlock = 1'b0; branch = 1'b0;
      chk("fls_cnt", {28'd0, p_flush}, 32'd1);
      chk("fls_stall_same", {28'd0, p_stall}, 32'd3);

      // Flush raised under a memory stall is acted on at release
      req = 1'b1; branch = 1'b1; settle;
      chk("fls_in_mstall", {24'd0, vec}, {24'd0, V_MST});
      nxt; ack = 1'b1; settle;
      chk("fls_at_release", {24'd0, vec}, {24'd0, V_FLS});
      nxt; req = 1'b0; ack = 1'b0; branch = 1'b0;
      chk("fls_cnt2", {28'd0, p_flush}, 32'd2);
      chk("stall_after_fls", {28'd0, p_stall}, 32'd4);

      // Fetch starvation
      vld = 1'b0; settle;
      chk("novld_outs", {24'd0, vec}, {24'd0, V_NOV});
      nxt; vld = 1'b1;
      chk("novld_stall_cnt", {28'd0, p_stall}, 32'd5);

      // Counter saturation
      intrlock = 1'b1;
      repeat (20) nxt;
      intrlock = 1'b0;
      chk("sat_stall", {28'd0, p_stall}, 32'd15);
      chk("sat_cycles", {28'd0, p_cyc}, 32'd15);
      clr = 1'b1; settle;
      chk("sat_clr_outs", {24'd0, vec}, {24'd0, V_RUN});
      nxt; clr = 1'b0;
      chk("sat_clr_stall", {28'd0, p_stall}, 32'd0);
      chk("sat_clr_cycles", {28'd0, p_cyc}, 32'd0);

      // Watchdog at four stall cycles
      req = 1'b1; ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         settle;
         chk("wd_stalled", {24'd0, vec}, {24'd0, V_MST});
         chk("wd_err_low", {31'd0, err}, 32'd0);
         nxt;
      end
      settle;
      chk("wd_err_outs", {24'd0, vec}, {24'd0, V_OFF});
      chk("wd_err_high", {31'd0, err}, 32'd1);
      chk("wd_cycles_frozen", {28'd0, p_cyc}, 32'd4);
      chk("wd_stall_cnt", {28'd0, p_stall}, 32'd4);
      nxt; nxt; ack = 1'b1; settle;
      chk("wd_ack_ignored", {24'd0, vec}, {24'd0, V_OFF});
      chk("wd_err_sticky", {31'd0, err}, 32'd1);
      nxt; req = 1'b0; ack = 1'b0; settle;
      chk("wd_idle_outs", {24'd0, vec}, {24'd0, V_OFF});
      chk("wd_err_sticky2", {31'd0, err}, 32'd1);
      chk("wd_cycles_hold", {28'd0, p_cyc}, 32'd4);
      rst = 1'b1; settle;
      chk("wd_rst_outs", {24'd0, vec}, {24'd0, V_OFF});
      chk("wd_rst_err", {31'd0, err}, 32'd0);
      nxt; rst = 1'b0; settle;
      chk("wd_after_rst", {24'd0, vec}, {24'd0, V_RUN});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core (IF, DE, EX, MA, WB). It combines the decode load-use interlock, the execute branch flush, data-memory wait handshakes and fetch starvation into per-stage register enables and bubble/flush controls. It also runs a memory-stall watchdog and saturating performance counters. It sits beside the datapath, at core top level, and drives every pipe-register enable.

Parameters:
CNT_W, 32, width of each performance counter
MEM_TIMEOUT, 255, consecutive unacknowledged memory-stall cycles before fatal error; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
intrlock_bubble  in  1  load-use hazard from decode
ex_branch_flush  in  1  mispredict flush from execute
ma_mem_req  in  1  MA-stage instruction has an outstanding data-memory access
ma_mem_ack  in  1  data memory completes the access this cycle
if_inst_vld  in  1  fetch presents a valid instruction
perf_clr  in  1  synchronous clear of all perf counters
pc_en  out  1  PC register update enable
if_de_en  out  1  IF/DE register enable
if_de_flush  out  1  load BUBBLE into IF/DE
de_ex_en  out  1  DE/EX register enable
de_ex_bubble  out  1  load BUBBLE into DE/EX
ex_ma_en  out  1  EX/MA register enable
ma_wb_en  out  1  MA/WB register enable
ma_wb_bubble  out  1  load BUBBLE into MA/WB
mem_timeout_err  out  1  sticky watchdog error
perf_cycles  out  CNT_W  active cycles
perf_stall  out  CNT_W  cycles with pc_en=0 (excluding ERR)
perf_flush  out  CNT_W  flushes acted on

Behaviour:
- States: RUN, MEM_WAIT, ERR (registered). A timer of width clog2(MEM_TIMEOUT+1) counts consecutive stall cycles.
- Combinational term: mstall = ma_mem_req & ~ma_mem_ack. It is evaluated identically in RUN and MEM_WAIT.
- Output priority in RUN/MEM_WAIT, with the first match winning:
  1. mstall: pc_en, if_de_en, de_ex_en, ex_ma_en = 0; ma_wb_en=1 with ma_wb_bubble=1.
  2. ex_branch_flush: all enables = 1; if_de_flush=1; de_ex_bubble=1; intrlock_bubble is ignored.
  3. intrlock_bubble: pc_en=0, if_de_en=0; de_ex_en=1 with de_ex_bubble=1; ex_ma_en=1, ma_wb_en=1.
  4. ~if_inst_vld: pc_en=0; if_de_en=1 with if_de_flush=1; downstream enables = 1.
  5. Otherwise: all enables = 1, all bubbles/flushes = 0.
- A flush raised during mstall is held by the frozen EX stage and acted on in the release cycle.
- Transitions:
  - RUN -> MEM_WAIT on mstall; the timer loads 1.
  - MEM_WAIT and mstall: the timer increments. If the timer == MEM_TIMEOUT and MEM_TIMEOUT != 0, go to ERR.
  - MEM_WAIT and ~mstall (ack or request dropped): go to RUN, clear the timer. This release cycle uses the priority rules above, so the pipeline advances.
  - RUN with mstall and MEM_TIMEOUT == 1: go directly to ERR.
  - ERR: all enables, bubbles and flushes = 0. mem_timeout_err=1 (registered, rises in the first ERR cycle). ERR is exited only by rst; a later ack is ignored.
- Counters: each is a saturating unsigned counter that holds at all-ones.
  - perf_cycles increments every non-ERR cycle.
  - perf_stall increments when pc_en=0 and the state is not ERR.
  - perf_flush increments on cycles where rule 2 is selected.
  - perf_clr forces all counters to 0 that cycle; clear wins over increment.
- Reset (asynchronous, any state, including mid MEM_WAIT):
  - State = RUN, timer = 0, counters = 0, mem_timeout_err = 0.
  - While rst=1, all enables, bubbles and flushes are forced to 0.
  - The first cycle after deassertion follows the RUN rules.
- Latency: all stage controls are combinational from the inputs and the current state, so they act in the same cycle. Error and counters are visible one cycle after their cause.

Decomposition:
- utils_top package: hz_state_t enum {HZ_RUN, HZ_MEM_WAIT, HZ_ERR}; the existing BUBBLE constant is reused by the datapath when a bubble signal is set.
- One sub-module, pipe_sat_cnt (parameter W; ports clk, rst, clr, inc, cnt), instantiated three times.

Test Plan:
- Reset mid MEM_WAIT: req=1, ack=0 for 3 cycles, then assert rst. Required: all outputs 0 at once; after release the state is RUN, counters are 0, and pc_en=1 with all inputs idle and if_inst_vld=1.
- Load-use: intrlock_bubble=1 for one cycle. Required: pc_en=0, if_de_en=0, de_ex_bubble=1, ex_ma_en=1; perf_stall increases by 1 the next cycle.
- Memory wait: req=1 with ack=0 for cycles 0-2 and ack=1 at cycle 3. Required: cycles 0-2 frozen with ma_wb_bubble=1; cycle 3 all enables = 1; perf_stall=3; mem_timeout_err stays 0.
- Flush vs interlock, same cycle. Required: pc_en=1, if_de_flush=1, de_ex_bubble=1; perf_flush=1; perf_stall unchanged.
- Watchdog with MEM_TIMEOUT=4: req=1 and ack=0 from cycle 0. Required: cycles 0-3 stalled; mem_timeout_err=1 from cycle 4 onward; ack=1 at cycle 6 ignored; all enables remain 0 until rst.
- Saturation with CNT_W=4: hold intrlock_bubble=1 for 20 cycles. Required: perf_stall holds at 15. Then pulse perf_clr. Required: perf_stall=0 the next cycle; perf_cycles also 0.
